// File: rtl/pet_pkg.sv
// Shared state encoding and widths for the pet care-chain engine.
// Pure constants and helpers; no logic, no latency, no flow control.
package pet_pkg;
   localparam int ST_DONE   = 0;
   localparam int ST_IDLE   = 1;
   localparam int ST_STAGE0 = 2;
   localparam int SECS_W    = 12;

   function automatic int st_stage(input int k);
      return ST_STAGE0 + k;
   endfunction

   function automatic int st_dead(input int n);
      return ST_STAGE0 + n;
   endfunction
endpackage

// File: rtl/pet_tick_gen.sv
// One-second prescaler: o_tick pulses for one cycle when the count is CLK_HZ-1.
// o_tick is combinational from the counter; free-running, no backpressure.
module pet_tick_gen #(
   parameter int CLK_HZ = 50000000
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == PW'(CLK_HZ - 1));
   assign o_tick = w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_cnt <= '0;
      else if (w_last) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/pet_state_engine.sv
// N-stage pet care chain (proximity start, button advance, seconds timeout); PET_HEALTH_EN adds health/DEAD.
// State moves one cycle after a qualifying event (buttons add 2 sync + 1 edge cycle); no backpressure.
module pet_state_engine import pet_pkg::*; #(
   parameter  int CLK_HZ     = 50000000,
   parameter  int TIMEOUT_S  = 60,
   parameter  int NEED_N     = 2,
   parameter  int DIST_TH_CM = 5,
   parameter  int CM_W       = 16,
   parameter  int HEALTH_MAX = 7,
   localparam int STATE_W    = $clog2(NEED_N + 3),
   localparam int HEALTH_W   = $clog2(HEALTH_MAX + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [CM_W-1:0]     prox_cm,
   input  logic [NEED_N-1:0]   act,
   output logic [STATE_W-1:0]  state,
   output logic [SECS_W-1:0]   secs,
   output logic                sensor_hold,
   output logic                tick_1s,
   output logic                done_pulse,
   output logic [HEALTH_W-1:0] health
);
   localparam logic [STATE_W-1:0] S_DONE   = STATE_W'(ST_DONE);
   localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(ST_IDLE);
   localparam logic [STATE_W-1:0] S_STAGE0 = STATE_W'(ST_STAGE0);
   localparam logic [STATE_W-1:0] S_LAST   = STATE_W'(st_stage(NEED_N - 1));
`ifdef PET_HEALTH_EN
   localparam logic [STATE_W-1:0] S_DEAD   = STATE_W'(st_dead(NEED_N));
`endif

   logic [NEED_N-1:0]  r_act_s1, r_act_s2, r_act_d, w_act_rise;
   logic [STATE_W-1:0] r_state, w_nxt, w_stage_nxt;
   logic [SECS_W-1:0]  r_secs;
   logic               r_sensor_hold, r_done_pulse;
   logic               w_tick, w_timeout, w_is_stage, w_cur_rise, w_secs_clr;
   logic               w_hold_nxt, w_done_nxt;
`ifdef PET_HEALTH_EN
   logic [HEALTH_W-1:0] r_health, w_health_nxt;
`endif

   pet_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_act_s1 <= '0;
         r_act_s2 <= '0;
         r_act_d  <= '0;
      end else begin
         r_act_s1 <= act;
         r_act_s2 <= r_act_s1;
         r_act_d  <= r_act_s2;
      end
   end

   assign w_act_rise = r_act_s2 & ~r_act_d;
   assign w_timeout  = w_tick && (r_secs == SECS_W'(TIMEOUT_S - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_sensor_hold <= 1'b0;
         r_done_pulse  <= 1'b0;
      end else begin
         r_state       <= w_nxt;
         r_sensor_hold <= w_hold_nxt;
         r_done_pulse  <= w_done_nxt;
      end
   end

   always_comb begin
      w_is_stage  = 1'b0;
      w_cur_rise  = 1'b0;
      w_stage_nxt = r_state;
      for (int k = 0; k < NEED_N; k++) begin
         if (r_state == STATE_W'(st_stage(k))) begin
            w_is_stage  = 1'b1;
            w_cur_rise  = w_act_rise[k];
            w_stage_nxt = (k == NEED_N - 1) ? S_DONE : STATE_W'(st_stage(k + 1));
         end
      end
      w_nxt      = r_state;
      w_secs_clr = 1'b0;
`ifdef PET_HEALTH_EN
      w_health_nxt = r_health;
      if (r_state == S_DEAD) begin
      end else
`endif
      if (w_timeout) begin
         // An IDLE timeout only restarts the seconds count.
         w_secs_clr = 1'b1;
         if (w_is_stage) begin
`ifdef PET_HEALTH_EN
            if (r_health != '0) w_health_nxt = r_health - 1'b1;
            w_nxt = (r_health <= HEALTH_W'(1)) ? S_DEAD : S_IDLE;
`else
            w_nxt = S_IDLE;
`endif
         end else if (r_state == S_DONE) begin
            w_nxt = S_IDLE;
         end
      end else if (r_state == S_IDLE && !enable && prox_cm <= CM_W'(DIST_TH_CM)) begin
         w_nxt      = S_STAGE0;
         w_secs_clr = 1'b1;
      end else if (w_is_stage && enable && w_cur_rise) begin
         w_nxt      = w_stage_nxt;
         w_secs_clr = 1'b1;
`ifdef PET_HEALTH_EN
         if (w_stage_nxt == S_DONE && r_health != HEALTH_W'(HEALTH_MAX))
            w_health_nxt = r_health + 1'b1;
`endif
      end
   end

   always_comb begin
      w_hold_nxt = (w_nxt >= S_STAGE0) && (w_nxt <= S_LAST);
      w_done_nxt = (w_nxt == S_DONE) && (r_state != S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           r_secs <= '0;
      else if (w_secs_clr)                 r_secs <= '0;
      else if (w_tick && r_secs != '1)     r_secs <= r_secs + 1'b1;
   end

`ifdef PET_HEALTH_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_health <= HEALTH_W'(HEALTH_MAX);
      else       r_health <= w_health_nxt;
   end
   assign health = r_health;
`else
   assign health = HEALTH_W'(HEALTH_MAX);
`endif

   assign state       = r_state;
   assign secs        = r_secs;
   assign sensor_hold = r_sensor_hold;
   assign done_pulse  = r_done_pulse;
   assign tick_1s     = w_tick;
endmodule

// File: tb/tb_pet_state_engine.sv
// Scoreboard bench for pet_state_engine: CLK_HZ=10, TIMEOUT_S=4, NEED_N=2, HEALTH_MAX=2.
// Health/DEAD scenarios run when PET_HEALTH_EN is defined, the tied-health scenario otherwise.
module tb_pet_state_engine;
   localparam int CLK_HZ = 10, TIMEOUT_S = 4, NEED_N = 2, HEALTH_MAX = 2;
`ifdef PET_HEALTH_EN
   localparam logic [1:0] H_AFTER_TO = 2'd1;
`else
   localparam logic [1:0] H_AFTER_TO = 2'd2;
`endif

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] hl;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, enable;
   logic [15:0] prox_cm;
   logic [1:0]  act;
   logic [2:0]  state;
   logic [11:0] secs;
   logic        sensor_hold, tick_1s, done_pulse;
   logic [1:0]  health;

   int   n_cmp = 0, n_bad = 0, n_done = 0;
   exp_t sb[$];
   exp_t e;

   pet_state_engine #(
      .CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .NEED_N(NEED_N),
      .DIST_TH_CM(5), .CM_W(16), .HEALTH_MAX(HEALTH_MAX)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .prox_cm(prox_cm), .act(act),
      .state(state), .secs(secs), .sensor_hold(sensor_hold), .tick_1s(tick_1s),
      .done_pulse(done_pulse), .health(health)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done_pulse === 1'b1) n_done++;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, output int taken);
      taken = 0;
      while (state !== target && taken < budget) begin
         cyc(1);
         taken++;
      end
   endtask

   task automatic do_reset;
      reset = 1'b1; enable = 1'b0; prox_cm = 16'd100; act = 2'b00;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic enter_stage0;
      enable = 1'b0; prox_cm = 16'd5;
      cyc(1);
      prox_cm = 16'd100; enable = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b0; prox_cm = 16'd100; act = 2'b00;
      sb.push_back('{st: 3'd1, hl: 2'd2});
      #2;
      e = sb.pop_front();
      n_cmp++; if (state !== e.st) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, e.st); end
      n_cmp++; if (health !== e.hl) begin n_bad++; $display("FAIL reset_health: got %0d want %0d", health, e.hl); end
      n_cmp++; if ({secs, sensor_hold, tick_1s, done_pulse} !== 15'd0)
         begin n_bad++; $display("FAIL reset_outs: secs=%0d hold=%b tick=%b done=%b want all 0", secs, sensor_hold, tick_1s, done_pulse); end
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic test_full_chain;
      int d0;
      do_reset;
      d0 = n_done;
      sb.push_back('{st: 3'd2, hl: 2'd2});
      enable = 1'b0; prox_cm = 16'd5;
      cyc(1);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || sensor_hold !== 1'b1)
         begin n_bad++; $display("FAIL chain_prox: state=%0d hold=%b want %0d/1", state, sensor_hold, e.st); end
      prox_cm = 16'd100; enable = 1'b1;
      sb.push_back('{st: 3'd3, hl: 2'd2});
      act = 2'b01; cyc(1); act = 2'b00; cyc(1);
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL chain_act0_early: state=%0d want 2", state); end
      cyc(1);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st) begin n_bad++; $display("FAIL chain_act0: state=%0d want %0d", state, e.st); end
      sb.push_back('{st: 3'd0, hl: 2'd2});
      act = 2'b10; cyc(1); act = 2'b00; cyc(2);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || done_pulse !== 1'b1 || health !== e.hl)
         begin n_bad++; $display("FAIL chain_done: state=%0d done=%b health=%0d want %0d/1/%0d", state, done_pulse, health, e.st, e.hl); end
      cyc(1);
      n_cmp++; if (done_pulse !== 1'b0 || sensor_hold !== 1'b0 || (n_done - d0) != 1)
         begin n_bad++; $display("FAIL chain_after: done=%b hold=%b pulses=%0d want 0/0/1", done_pulse, sensor_hold, n_done - d0); end
   endtask

   task automatic test_threshold;
      logic moved;
      do_reset;
      moved = 1'b0;
      enable = 1'b0; prox_cm = 16'd6;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (state !== 3'd1) moved = 1'b1;
      end
      n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL thresh_6: left idle=%b want 0", moved); end
      sb.push_back('{st: 3'd2, hl: 2'd2});
      prox_cm = 16'd5;
      cyc(1);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st) begin n_bad++; $display("FAIL thresh_5: state=%0d want %0d", state, e.st); end
   endtask

   task automatic test_wrong_held;
      int d0;
      do_reset;
      enter_stage0;
      d0 = n_done;
      sb.push_back('{st: 3'd2, hl: 2'd2});
      act = 2'b10;
      cyc(6);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st) begin n_bad++; $display("FAIL wrong_btn: state=%0d want %0d", state, e.st); end
      // act[1] stays held, so reaching the last stage must not complete the chain
      sb.push_back('{st: 3'd3, hl: 2'd2});
      act = 2'b11;
      cyc(25);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || (n_done - d0) != 0)
         begin n_bad++; $display("FAIL held_btn: state=%0d pulses=%0d want %0d/0", state, n_done - d0, e.st); end
      act = 2'b00;
   endtask

   task automatic test_collision;
      int guard;
      do_reset;
      enter_stage0;
      guard = 0;
      while (!(secs === 12'd2 && tick_1s === 1'b1) && guard < 60) begin
         cyc(1);
         guard++;
      end
      cyc(8);
      act = 2'b01; cyc(1); act = 2'b00; cyc(1);
      n_cmp++; if (tick_1s !== 1'b1 || secs !== 12'd3)
         begin n_bad++; $display("FAIL collide_tick: tick=%b secs=%0d want 1/3", tick_1s, secs); end
      sb.push_back('{st: 3'd1, hl: H_AFTER_TO});
      cyc(1);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || health !== e.hl || secs !== 12'd0)
         begin n_bad++; $display("FAIL collide: state=%0d health=%0d secs=%0d want %0d/%0d/0", state, health, secs, e.st, e.hl); end
      cyc(6);
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL collide_lost: state=%0d want 1", state); end
   endtask

`ifdef PET_HEALTH_EN
   task automatic test_timeout_death;
      int taken;
      do_reset;
      enter_stage0;
      sb.push_back('{st: 3'd1, hl: 2'd1});
      wait_state(3'd1, 60, taken);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || health !== e.hl || taken < 30 || taken > 41)
         begin n_bad++; $display("FAIL timeout1: state=%0d health=%0d cycles=%0d want %0d/%0d/30..41", state, health, taken, e.st, e.hl); end
      enter_stage0;
      sb.push_back('{st: 3'd4, hl: 2'd0});
      wait_state(3'd4, 60, taken);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || health !== e.hl || sensor_hold !== 1'b0)
         begin n_bad++; $display("FAIL death: state=%0d health=%0d hold=%b want %0d/%0d/0", state, health, sensor_hold, e.st, e.hl); end
      sb.push_back('{st: 3'd4, hl: 2'd0});
      enable = 1'b0; prox_cm = 16'd0; cyc(3);
      enable = 1'b1; act = 2'b11; cyc(3); act = 2'b00; act = 2'b01; cyc(3); act = 2'b00;
      cyc(50);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || health !== e.hl)
         begin n_bad++; $display("FAIL dead_sticky: state=%0d health=%0d want %0d/%0d", state, health, e.st, e.hl); end
   endtask
`else
   task automatic test_no_health;
      int taken;
      do_reset;
      for (int r = 0; r < 3; r++) begin
         enter_stage0;
         sb.push_back('{st: 3'd1, hl: 2'd2});
         wait_state(3'd1, 60, taken);
         e = sb.pop_front();
         n_cmp++; if (state !== e.st || health !== e.hl || taken < 30 || taken > 41)
            begin n_bad++; $display("FAIL nohealth_to%0d: state=%0d health=%0d cycles=%0d want %0d/%0d/30..41", r, state, health, taken, e.st, e.hl); end
      end
   endtask
`endif

   task automatic test_reset_mid;
      int taken;
      do_reset;
      enter_stage0;
      act = 2'b01; cyc(1); act = 2'b00;
      sb.push_back('{st: 3'd3, hl: 2'd2});
      wait_state(3'd3, 10, taken);
      e = sb.pop_front();
      n_cmp++; if (state !== e.st) begin n_bad++; $display("FAIL mid_pre: state=%0d want %0d", state, e.st); end
      sb.push_back('{st: 3'd1, hl: 2'd2});
      reset = 1'b1;
      #1;
      e = sb.pop_front();
      n_cmp++; if (state !== e.st || health !== e.hl || secs !== 12'd0 || sensor_hold !== 1'b0 || done_pulse !== 1'b0 || tick_1s !== 1'b0)
         begin n_bad++; $display("FAIL mid_reset: state=%0d health=%0d secs=%0d hold=%b done=%b tick=%b want %0d/%0d/0/0/0/0",
                                 state, health, secs, sensor_hold, done_pulse, tick_1s, e.st, e.hl); end
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      test_reset;
      test_full_chain;
      test_threshold;
      test_wrong_held;
      test_collision;
`ifdef PET_HEALTH_EN
      test_timeout_death;
`else
      test_no_health;
`endif
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
      $fatal(1, "time limit");
   end
endmodule
